// File: rtl/asic_cfg_serializer.sv
// Configuration loader: after a synchronised start and a settle wait, shifts the dynamic
// then the static shadow image MSB-first on MOSI with a gated serial clock SCLK.
module asic_cfg_serializer #(
  parameter int                DYN_W     = 16,
  parameter int                STAT_W    = 88,
  parameter logic [DYN_W-1:0]  DYN_INIT  = 16'hABC6,
  parameter logic [STAT_W-1:0] STAT_INIT = 88'h123456789ABCDEF1234567,
  parameter int                WAIT_CYC  = 200,
  parameter int                CLK_DIV   = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic              abort,
  input  logic              loop_en,
  input  logic              load_en,
  input  logic [DYN_W-1:0]  dyn_img,
  input  logic [STAT_W-1:0] stat_img,
  output logic              SEL,
  output logic              MOSI,
  output logic              SCLK,
  output logic              busy,
  output logic              done
);

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  localparam int CW = $clog2(max4(WAIT_CYC, DYN_W, STAT_W, 2 * CLK_DIV) + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DYN  = 3'd2,
    S_STAT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       phase_q, phase_d;
  logic [DYN_W-1:0]    dyn_shd_q, dyn_shd_d, dyn_wrk_q, dyn_wrk_d;
  logic [STAT_W-1:0]   stat_shd_q, stat_shd_d, stat_wrk_q, stat_wrk_d;
  logic                sync1_q, sync2_q, sync3_q;
  logic                sel_q, sel_d, mosi_q, mosi_d, sclk_q, sclk_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                start_rise_s, last_phase_s;

  assign start_rise_s = sync2_q & ~sync3_q;
  assign last_phase_s = (phase_q == CW'(2 * CLK_DIV - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    dyn_wrk_d  = dyn_wrk_q;
    stat_wrk_d = stat_wrk_q;
    dyn_shd_d  = dyn_shd_q;
    stat_shd_d = stat_shd_q;

    case (state_q)
      S_IDLE: begin
        if (start_rise_s) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == CW'(WAIT_CYC - 1)) begin
          state_d   = S_DYN;
          cnt_d     = '0;
          phase_d   = '0;
          dyn_wrk_d = dyn_shd_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DYN: begin
        if (last_phase_s) begin
          phase_d = '0;
          // Last dynamic bit hands straight over to the static image with no gap.
          if (cnt_q == CW'(DYN_W - 1)) begin
            state_d    = S_STAT;
            cnt_d      = '0;
            stat_wrk_d = stat_shd_q;
          end else begin
            cnt_d     = cnt_q + CW'(1);
            dyn_wrk_d = {dyn_wrk_q[DYN_W-2:0], 1'b0};
          end
        end else begin
          phase_d = phase_q + CW'(1);
        end
      end
      S_STAT: begin
        if (last_phase_s) begin
          phase_d = '0;
          if (cnt_q == CW'(STAT_W - 1)) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d      = cnt_q + CW'(1);
            stat_wrk_d = {stat_wrk_q[STAT_W-2:0], 1'b0};
          end
        end else begin
          phase_d = phase_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = loop_en ? S_WAIT : S_IDLE;
        cnt_d   = '0;
        phase_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        phase_d = '0;
      end
    endcase

    if ((state_q == S_IDLE || state_q == S_DONE) && load_en && !abort) begin
      dyn_shd_d  = dyn_img;
      stat_shd_d = stat_img;
    end else begin
      dyn_shd_d  = dyn_shd_q;
      stat_shd_d = stat_shd_q;
    end

    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      phase_d = '0;
    end else begin
      cnt_d   = cnt_d;
    end

    // Outputs are decoded from the next state so the registered pins line up with it.
    busy_d = (state_d == S_WAIT) || (state_d == S_DYN) || (state_d == S_STAT);
    done_d = (state_d == S_DONE);
    sel_d  = (state_d == S_DYN);
    sclk_d = ((state_d == S_DYN) || (state_d == S_STAT)) && (phase_d >= CW'(CLK_DIV));
    if (state_d == S_DYN) begin
      mosi_d = dyn_wrk_d[DYN_W-1];
    end else if (state_d == S_STAT) begin
      mosi_d = stat_wrk_d[STAT_W-1];
    end else begin
      mosi_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      phase_q    <= '0;
      dyn_shd_q  <= DYN_INIT;
      stat_shd_q <= STAT_INIT;
      dyn_wrk_q  <= '0;
      stat_wrk_q <= '0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      sel_q      <= 1'b0;
      mosi_q     <= 1'b0;
      sclk_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      dyn_shd_q  <= dyn_shd_d;
      stat_shd_q <= stat_shd_d;
      dyn_wrk_q  <= dyn_wrk_d;
      stat_wrk_q <= stat_wrk_d;
      sync1_q    <= start;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      sel_q      <= sel_d;
      mosi_q     <= mosi_d;
      sclk_q     <= sclk_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign SEL  = sel_q;
  assign MOSI = mosi_q;
  assign SCLK = sclk_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_asic_cfg_serializer.sv
// Directed bench for asic_cfg_serializer: a 16/88-bit instance (CLK_DIV=1, WAIT_CYC=4)
// and an 8/12-bit instance (CLK_DIV=3) whose serial streams are captured on SCLK rises.
module tb_asic_cfg_serializer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, abort = 1'b0, loop_en = 1'b0, load_en = 1'b0;
  logic [15:0]  dyn_img = 16'h0000;
  logic [87:0]  stat_img = 88'h0;
  logic         sel, mosi, sclk, busy, done;

  logic         start5 = 1'b0;
  logic         zero5 = 1'b0;
  logic [7:0]   dyn_img5 = 8'h00;
  logic [11:0]  stat_img5 = 12'h000;
  logic         sel5, mosi5, sclk5, busy5, done5;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  asic_cfg_serializer #(
    .DYN_W(16), .STAT_W(88), .DYN_INIT(16'hABC6),
    .STAT_INIT(88'h123456789ABCDEF1234567), .WAIT_CYC(4), .CLK_DIV(1)
  ) u_dut (
    .CLK(clk), .RST_N(rst_n), .start(start), .abort(abort), .loop_en(loop_en),
    .load_en(load_en), .dyn_img(dyn_img), .stat_img(stat_img),
    .SEL(sel), .MOSI(mosi), .SCLK(sclk), .busy(busy), .done(done)
  );

  asic_cfg_serializer #(
    .DYN_W(8), .STAT_W(12), .DYN_INIT(8'hB4), .STAT_INIT(12'hA5C),
    .WAIT_CYC(2), .CLK_DIV(3)
  ) u_dut5 (
    .CLK(clk), .RST_N(rst_n), .start(start5), .abort(zero5), .loop_en(zero5),
    .load_en(zero5), .dyn_img(dyn_img5), .stat_img(stat_img5),
    .SEL(sel5), .MOSI(mosi5), .SCLK(sclk5), .busy(busy5), .done(done5)
  );

  // Capture of the wide instance: shift MOSI on each SCLK rise, count done pulses.
  logic         cap_clr = 1'b0;
  logic         sclk_prev;
  logic [15:0]  dyn_cap;
  logic [87:0]  stat_cap;
  int           dyn_cnt, stat_cnt, done_cnt, done_run, done_run_max;

  always @(negedge clk) begin
    if (cap_clr) begin
      dyn_cap <= '0; stat_cap <= '0; dyn_cnt <= 0; stat_cnt <= 0;
      done_cnt <= 0; done_run <= 0; done_run_max <= 0;
    end else begin
      if (sclk && !sclk_prev) begin
        if (sel) begin
          dyn_cap <= {dyn_cap[14:0], mosi}; dyn_cnt <= dyn_cnt + 1;
        end else begin
          stat_cap <= {stat_cap[86:0], mosi}; stat_cnt <= stat_cnt + 1;
        end
      end
      if (done) begin
        if (done_run == 0) done_cnt <= done_cnt + 1;
        done_run <= done_run + 1;
        if (done_run + 1 > done_run_max) done_run_max <= done_run + 1;
      end else begin
        done_run <= 0;
      end
    end
    sclk_prev <= sclk;
  end

  // Capture of the narrow instance, plus SCLK high-time and rise-to-rise period tracking.
  logic         sclk5_prev;
  logic [7:0]   dyn_cap5;
  logic [11:0]  stat_cap5;
  int           rise5, done5_cnt, cyc5, last_rise5, hi_run5;
  int           hi_min5, hi_max5, per_min5, per_max5;

  always @(negedge clk) begin
    if (cap_clr) begin
      dyn_cap5 <= '0; stat_cap5 <= '0; rise5 <= 0; done5_cnt <= 0; cyc5 <= 0;
      last_rise5 <= -1; hi_run5 <= 0;
      hi_min5 <= 999; hi_max5 <= 0; per_min5 <= 999; per_max5 <= 0;
    end else begin
      cyc5 <= cyc5 + 1;
      if (done5) done5_cnt <= done5_cnt + 1;
      if (sclk5 && !sclk5_prev) begin
        rise5 <= rise5 + 1;
        if (sel5) dyn_cap5 <= {dyn_cap5[6:0], mosi5};
        else      stat_cap5 <= {stat_cap5[10:0], mosi5};
        if (last_rise5 >= 0) begin
          if (cyc5 - last_rise5 < per_min5) per_min5 <= cyc5 - last_rise5;
          if (cyc5 - last_rise5 > per_max5) per_max5 <= cyc5 - last_rise5;
        end
        last_rise5 <= cyc5;
      end
      if (sclk5) begin
        hi_run5 <= hi_run5 + 1;
      end else if (sclk5_prev) begin
        if (hi_run5 < hi_min5) hi_min5 <= hi_run5;
        if (hi_run5 > hi_max5) hi_max5 <= hi_run5;
        hi_run5 <= 0;
      end
    end
    sclk5_prev <= sclk5;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_cap();
    @(posedge clk); cap_clr = 1'b1;
    @(posedge clk); cap_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 128'(done), 128'(1'b1));
  endtask

  task automatic check_frame(input string tag, input logic [15:0] d, input logic [87:0] s);
    repeat (3) @(negedge clk);
    chk({tag, "_dyn"}, 128'(dyn_cap), 128'(d));
    chk({tag, "_stat"}, 128'(stat_cap), 128'(s));
    chk({tag, "_dyn_n"}, 128'(dyn_cnt), 128'(16));
    chk({tag, "_stat_n"}, 128'(stat_cnt), 128'(88));
  endtask

  initial begin
    int k;
    logic [87:0] ones88;
    ones88 = '1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sel", 128'(sel), 128'(1'b0));
    chk("rst_mosi", 128'(mosi), 128'(1'b0));
    chk("rst_sclk", 128'(sclk), 128'(1'b0));
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_done", 128'(done), 128'(1'b0));
    rst_n = 1'b1;
    clr_cap();

    // T1: latency and default frame
    @(negedge clk); start = 1'b1;
    @(negedge clk); chk("lat_1", 128'(busy), 128'(1'b0));
    @(negedge clk); chk("lat_2", 128'(busy), 128'(1'b0));
    @(negedge clk); chk("lat_3", 128'(busy), 128'(1'b1));
    start = 1'b0;
    wait_done("t1_done", 400);
    check_frame("t1", 16'hABC6, 88'h123456789ABCDEF1234567);
    chk("t1_done_cnt", 128'(done_cnt), 128'(1));
    chk("t1_done_w", 128'(done_run_max), 128'(1));

    // T2: runtime image load, then a load attempt mid-STAT
    @(negedge clk); load_en = 1'b1; dyn_img = 16'h0001; stat_img = ones88;
    @(negedge clk); load_en = 1'b0;
    clr_cap();
    pulse_start();
    wait_done("t2_done", 400);
    check_frame("t2", 16'h0001, ones88);
    clr_cap();
    pulse_start();
    k = 0;
    while (!(busy && !sel && stat_cnt >= 5) && k < 400) begin @(negedge clk); k++; end
    chk("t2_reach_stat", 128'(stat_cnt >= 5), 128'(1'b1));
    load_en = 1'b1; dyn_img = 16'h5A5A; stat_img = 88'h0F0F0F0F0F0F0F0F0F0F0F;
    @(negedge clk); load_en = 1'b0;
    wait_done("t2b_done", 400);
    check_frame("t2b", 16'h0001, ones88);
    clr_cap();
    pulse_start();
    wait_done("t2c_done", 400);
    check_frame("t2c", 16'h0001, ones88);

    // T3: abort during the dynamic register, then a clean frame
    @(negedge clk); load_en = 1'b1; dyn_img = 16'hA5C3; stat_img = 88'hFEDCBA9876543210ABCDEF;
    @(negedge clk); load_en = 1'b0;
    clr_cap();
    pulse_start();
    k = 0;
    while (dyn_cnt != 9 && k < 400) begin @(negedge clk); k++; end
    chk("t3_reach_bit10", 128'(dyn_cnt), 128'(9));
    abort = 1'b1;
    @(negedge clk);
    chk("t3_sel", 128'(sel), 128'(1'b0));
    chk("t3_mosi", 128'(mosi), 128'(1'b0));
    chk("t3_sclk", 128'(sclk), 128'(1'b0));
    chk("t3_busy", 128'(busy), 128'(1'b0));
    abort = 1'b0;
    repeat (6) @(negedge clk);
    chk("t3_no_done", 128'(done_cnt), 128'(0));
    clr_cap();
    pulse_start();
    wait_done("t3_done", 400);
    check_frame("t3", 16'hA5C3, 88'hFEDCBA9876543210ABCDEF);

    // T4: loop mode; done-to-first-rise gap = WAIT_CYC+1+CLK_DIV = 6
    clr_cap();
    loop_en = 1'b1;
    pulse_start();
    wait_done("t4_done1", 400);
    k = 0;
    do begin @(negedge clk); k++; end while (sclk !== 1'b1 && k < 50);
    chk("t4_gap", 128'(k), 128'(6));
    wait_done("t4_done2", 400);
    @(negedge clk);
    chk("t4_done_cnt2", 128'(done_cnt), 128'(2));
    loop_en = 1'b0;
    wait_done("t4_done3", 400);
    repeat (3) @(negedge clk);
    chk("t4_idle", 128'(busy), 128'(1'b0));
    chk("t4_done_cnt3", 128'(done_cnt), 128'(3));
    chk("t4_done_w", 128'(done_run_max), 128'(1));

    // T5: narrow instance, CLK_DIV=3
    clr_cap();
    @(negedge clk); start5 = 1'b1;
    repeat (3) @(negedge clk); start5 = 1'b0;
    k = 0;
    while (done5 !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    chk("t5_done", 128'(done5), 128'(1'b1));
    repeat (3) @(negedge clk);
    chk("t5_rises", 128'(rise5), 128'(20));
    chk("t5_dyn", 128'(dyn_cap5), 128'(8'hB4));
    chk("t5_stat", 128'(stat_cap5), 128'(12'hA5C));
    chk("t5_hi_min", 128'(hi_min5), 128'(3));
    chk("t5_hi_max", 128'(hi_max5), 128'(3));
    chk("t5_per_min", 128'(per_min5), 128'(6));
    chk("t5_per_max", 128'(per_max5), 128'(6));
    chk("t5_done_cnt", 128'(done5_cnt), 128'(1));

    // T6: reset mid-STAT restores default images; start glitch while busy is ignored
    clr_cap();
    pulse_start();
    k = 0;
    while (stat_cnt < 10 && k < 400) begin @(negedge clk); k++; end
    chk("t6_reach_stat", 128'(stat_cnt >= 10), 128'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 128'(busy), 128'(1'b0));
    chk("t6_rst_sclk", 128'(sclk), 128'(1'b0));
    chk("t6_rst_mosi", 128'(mosi), 128'(1'b0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clr_cap();
    pulse_start();
    k = 0;
    while (!(busy && sel) && k < 100) begin @(negedge clk); k++; end
    chk("t6_in_dyn", 128'(sel), 128'(1'b1));
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done("t6_done", 400);
    check_frame("t6", 16'hABC6, 88'h123456789ABCDEF1234567);
    repeat (20) @(negedge clk);
    chk("t6_glitch_busy", 128'(busy), 128'(1'b0));
    chk("t6_glitch_done", 128'(done_cnt), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
